// File: rtl/rv4028_rom_arbiter.sv
// -----------------------------------------------------------------------------
// rv4028_rom_arbiter
//
// Purpose:
//   Lets the instruction-fetch unit and the load/store unit share the single
//   ported 16-bit synchronous boot ROM. The block accepts one 32-bit or 16-bit
//   request at a time. When both units request in the same cycle, it picks one
//   round-robin. For the granted request it issues one or two halfword ROM
//   reads, then returns the assembled word with a one-cycle ready pulse.
//   Ready always arrives 3 cycles after the request is sampled, and a new
//   request can be sampled every 5 cycles.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst       in   1   synchronous active-high reset
//   if_req    in   1   fetch request, held until if_ready
//   if_addr   in  11   fetch halfword address (always a 32-bit access)
//   if_ready  out  1   one-cycle pulse, if_data valid
//   if_data   out 32   fetch result {hi, lo}
//   d_req     in   1   data request, held until d_ready
//   d_addr    in  11   data halfword address
//   d_half    in   1   1 = 16-bit access, 0 = 32-bit access
//   d_ready   out  1   one-cycle pulse, d_data valid
//   d_data    out 32   data result ({16'h0, lo} for half accesses)
//   rom_ren   out  1   ROM read enable
//   rom_addr  out 11   ROM halfword address
//   rom_data  in  16   ROM read data, registered (1-cycle latency)
// -----------------------------------------------------------------------------
module rv4028_rom_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [10:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    input  logic        d_req,
    input  logic [10:0] d_addr,
    input  logic        d_half,
    output logic        d_ready,
    output logic [31:0] d_data,
    output logic        rom_ren,
    output logic [10:0] rom_addr,
    input  logic [15:0] rom_data
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LO   = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    logic [2:0]  r_state;
    logic        r_owner;
    logic        r_last_grant;
    logic        r_half;
    logic        r_wait_ext;
    logic [10:0] r_addr;
    logic [15:0] r_lo;
    logic        r_rom_ren;
    logic [10:0] r_rom_addr;
    logic        r_if_ready;
    logic [31:0] r_if_data;
    logic        r_d_ready;
    logic [31:0] r_d_data;

    logic        w_any_req;
    logic        w_grant_d;
    logic [10:0] w_grant_addr;
    logic        w_grant_half;
    logic [10:0] w_addr_inc;
    logic [31:0] w_word;

    // Data wins when it is the only requester, or when both request and fetch
    // was the previous owner.
    assign w_any_req    = if_req | d_req;
    assign w_grant_d    = d_req & (~if_req | (r_last_grant == OWN_IF));
    assign w_grant_addr = w_grant_d ? d_addr : if_addr;
    assign w_grant_half = w_grant_d & d_half;

    // 11-bit increment; wraps 7FF -> 000 naturally.
    assign w_addr_inc = r_addr + 11'd1;

    // In WAIT, rom_data holds hi for a word access. For a half access it still
    // holds lo, because the ROM keeps its output while ren is low.
    assign w_word = r_half ? {16'h0000, rom_data} : {rom_data, r_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_IF;
            r_last_grant <= OWN_D;
            r_half       <= 1'b0;
            r_wait_ext   <= 1'b0;
            r_rom_ren    <= 1'b0;
            r_rom_addr   <= 11'd0;
            r_if_ready   <= 1'b0;
            r_if_data    <= 32'd0;
            r_d_ready    <= 1'b0;
            r_d_data     <= 32'd0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_grant_d;
                        r_last_grant <= w_grant_d;
                        r_half       <= w_grant_half;
                        r_rom_ren    <= 1'b1;
                        r_rom_addr   <= w_grant_addr;
                        r_state      <= S_LO;
                    end
                end
                S_LO: begin
                    if (r_half) begin
                        // A half access skips HI. It spends one extra cycle in
                        // WAIT, so ready comes at the same latency as a word
                        // access.
                        r_rom_ren  <= 1'b0;
                        r_wait_ext <= 1'b1;
                        r_state    <= S_WAIT;
                    end else begin
                        r_rom_addr <= w_addr_inc;
                        r_state    <= S_HI;
                    end
                end
                S_HI: begin
                    r_rom_ren <= 1'b0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_ext) begin
                        r_wait_ext <= 1'b0;
                    end else begin
                        if (r_owner == OWN_D) begin
                            r_d_ready <= 1'b1;
                            r_d_data  <= w_word;
                        end else begin
                            r_if_ready <= 1'b1;
                            r_if_data  <= w_word;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_rom_ren <= 1'b0;
                end
            endcase
        end
    end

    // Latched address and the low halfword need no reset. They are always
    // written before they are used.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_any_req) begin
            r_addr <= w_grant_addr;
        end
        if (r_state == S_HI) begin
            r_lo <= rom_data;
        end
    end

    assign if_ready = r_if_ready;
    assign if_data  = r_if_data;
    assign d_ready  = r_d_ready;
    assign d_data   = r_d_data;
    assign rom_ren  = r_rom_ren;
    assign rom_addr = r_rom_addr;

endmodule

// File: tb/tb_rv4028_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rv4028_rom_arbiter
//
// Directed testbench for rv4028_rom_arbiter. A behavioral ROM model returns
// rom[i] = {5'h0, i}. Inputs are driven 1 time unit after a rising edge, and
// outputs are sampled at that same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rv4028_rom_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [10:0] if_addr;
    logic        if_ready;
    logic [31:0] if_data;
    logic        d_req;
    logic [10:0] d_addr;
    logic        d_half;
    logic        d_ready;
    logic [31:0] d_data;
    logic        rom_ren;
    logic [10:0] rom_addr;
    logic [15:0] rom_data;

    int n_tests = 0;
    int n_fail  = 0;

    rv4028_rom_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ready (if_ready),
        .if_data  (if_data),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_half   (d_half),
        .d_ready  (d_ready),
        .d_data   (d_data),
        .rom_ren  (rom_ren),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: each word equals its own index; output holds when ren=0.
    always_ff @(posedge clk) begin
        if (rom_ren) rom_data <= {5'h00, rom_addr};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        if_addr = 11'd0; d_addr = 11'd0; d_half = 1'b0;
        tick(); tick();
        n_tests++; if (rom_ren !== 1'b0) begin n_fail++; $display("FAIL reset_rom_ren got=%0h exp=0", rom_ren); end
        n_tests++; if (rom_addr !== 11'h000) begin n_fail++; $display("FAIL reset_rom_addr got=%0h exp=0", rom_addr); end
        n_tests++; if (if_ready !== 1'b0 || d_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%0b%0b exp=00", if_ready, d_ready); end
        n_tests++; if (if_data !== 32'h0 || d_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h/%h exp=0/0", if_data, d_data); end
        rst = 1'b0;
        tick();
        n_tests++; if (rom_ren !== 1'b0) begin n_fail++; $display("FAIL idle_rom_ren got=%0h exp=0", rom_ren); end
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 11'h010;
        tick(); // E0
        n_tests++; if (rom_ren !== 1'b1 || rom_addr !== 11'h010) begin n_fail++; $display("FAIL fetch_lo got=%0b/%h exp=1/010", rom_ren, rom_addr); end
        tick(); // E1
        n_tests++; if (rom_ren !== 1'b1 || rom_addr !== 11'h011) begin n_fail++; $display("FAIL fetch_hi got=%0b/%h exp=1/011", rom_ren, rom_addr); end
        tick(); // E2
        n_tests++; if (rom_ren !== 1'b0 || if_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_wait got ren=%0b rdy=%0b exp=0/0", rom_ren, if_ready); end
        n_tests++; if (rom_addr !== 11'h011) begin n_fail++; $display("FAIL fetch_addr_hold got=%h exp=011", rom_addr); end
        tick(); // E3
        n_tests++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL fetch_ready got=%0b exp=1", if_ready); end
        n_tests++; if (if_data !== 32'h0011_0010) begin n_fail++; $display("FAIL fetch_data got=%h exp=00110010", if_data); end
        n_tests++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_d_ready got=%0b exp=0", d_ready); end
        if_req = 1'b0;
        tick(); // E4
        n_tests++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse_len got=%0b exp=0", if_ready); end
        n_tests++; if (if_data !== 32'h0011_0010) begin n_fail++; $display("FAIL fetch_data_hold got=%h exp=00110010", if_data); end
        tick();
    endtask

    task automatic test_half();
        int ren_cnt;
        ren_cnt = 0;
        d_req = 1'b1; d_addr = 11'h123; d_half = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rom_ren === 1'b1) ren_cnt++;
            if (i == 0) begin
                n_tests++; if (rom_addr !== 11'h123) begin n_fail++; $display("FAIL half_addr got=%h exp=123", rom_addr); end
            end
            if (i == 3) begin
                n_tests++; if (d_ready !== 1'b1 || d_data !== 32'h0000_0123) begin n_fail++; $display("FAIL half_ready got=%0b/%h exp=1/00000123", d_ready, d_data); end
                d_req = 1'b0;
            end else begin
                n_tests++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL half_ready_low cyc=%0d got=%0b exp=0", i, d_ready); end
            end
            n_tests++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL half_if_ready cyc=%0d got=%0b exp=0", i, if_ready); end
        end
        n_tests++; if (ren_cnt != 1) begin n_fail++; $display("FAIL half_ren_cycles got=%0d exp=1", ren_cnt); end
        n_tests++; if (if_data !== 32'h0011_0010) begin n_fail++; $display("FAIL half_if_data_hold got=%h exp=00110010", if_data); end
        d_half = 1'b0;
    endtask

    task automatic test_wrap();
        if_req = 1'b1; if_addr = 11'h7FF;
        tick(); // E0
        n_tests++; if (rom_addr !== 11'h7FF) begin n_fail++; $display("FAIL wrap_lo got=%h exp=7ff", rom_addr); end
        tick(); // E1
        n_tests++; if (rom_addr !== 11'h000) begin n_fail++; $display("FAIL wrap_hi got=%h exp=000", rom_addr); end
        tick(); tick(); // E3
        n_tests++; if (if_ready !== 1'b1 || if_data !== 32'h0000_07FF) begin n_fail++; $display("FAIL wrap_data got=%0b/%h exp=1/000007ff", if_ready, if_data); end
        if_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        int pulses;
        int cyc[4];
        bit who[4];
        pulses = 0;
        for (int k = 0; k < 4; k++) begin cyc[k] = 0; who[k] = 1'b0; end
        rst = 1'b1;
        if_req = 1'b1; if_addr = 11'h004;
        d_req = 1'b1; d_addr = 11'h200; d_half = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 40 && pulses < 4; c++) begin
            tick();
            if (if_ready === 1'b1 || d_ready === 1'b1) begin
                n_tests++; if (if_ready === d_ready) begin n_fail++; $display("FAIL b2b_both_ready cyc=%0d", c); end
                cyc[pulses] = c;
                who[pulses] = d_ready;
                if (d_ready === 1'b1) begin
                    n_tests++; if (d_data !== 32'h0201_0200) begin n_fail++; $display("FAIL b2b_d_data got=%h exp=02010200", d_data); end
                end else begin
                    n_tests++; if (if_data !== 32'h0005_0004) begin n_fail++; $display("FAIL b2b_if_data got=%h exp=00050004", if_data); end
                end
                if (pulses == 0) begin
                    n_tests++; if (d_data !== 32'h0) begin n_fail++; $display("FAIL b2b_d_data_hold got=%h exp=0", d_data); end
                end
                pulses++;
            end
        end
        n_tests++; if (pulses != 4) begin n_fail++; $display("FAIL b2b_timeout pulses=%0d exp=4", pulses); end
        n_tests++; if (cyc[0] != 3) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=3", cyc[0]); end
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (who[k] !== k[0]) begin n_fail++; $display("FAIL b2b_order idx=%0d got=%0b exp=%0b", k, who[k], k[0]); end
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++; if (cyc[k+1] - cyc[k] != 5) begin n_fail++; $display("FAIL b2b_gap idx=%0d got=%0d exp=5", k, cyc[k+1] - cyc[k]); end
        end
        if_req = 1'b0; d_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        if_req = 1'b1; if_addr = 11'h020;
        tick(); // E0 -> LO
        tick(); // E1 -> HI
        rst = 1'b1; if_req = 1'b0;
        tick();
        n_tests++; if (rom_ren !== 1'b0 || rom_addr !== 11'h000) begin n_fail++; $display("FAIL rstmid_rom got=%0b/%h exp=0/000", rom_ren, rom_addr); end
        n_tests++; if (if_ready !== 1'b0 || d_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready got=%0b%0b exp=00", if_ready, d_ready); end
        n_tests++; if (if_data !== 32'h0 || d_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_data got=%h/%h exp=0/0", if_data, d_data); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (if_ready !== 1'b0) stray++;
        end
        n_tests++; if (stray != 0) begin n_fail++; $display("FAIL rstmid_stray_ready got=%0d exp=0", stray); end
        if_req = 1'b1; if_addr = 11'h030;
        tick(); tick(); tick(); tick(); // E3
        n_tests++; if (if_ready !== 1'b1 || if_data !== 32'h0031_0030) begin n_fail++; $display("FAIL rstmid_recover got=%0b/%h exp=1/00310030", if_ready, if_data); end
        if_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_addr_latch();
        d_req = 1'b1; d_addr = 11'h040; d_half = 1'b0;
        tick(); // E0 -> LO
        d_addr = 11'h050; d_half = 1'b1;
        tick(); // E1
        n_tests++; if (rom_addr !== 11'h041) begin n_fail++; $display("FAIL latch_hi_addr got=%h exp=041", rom_addr); end
        tick(); tick(); // E3
        n_tests++; if (d_ready !== 1'b1 || d_data !== 32'h0041_0040) begin n_fail++; $display("FAIL latch_data got=%0b/%h exp=1/00410040", d_ready, d_data); end
        d_req = 1'b0; d_half = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_half();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_addr_latch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
